rpi_serial_port: RTL and testbench
==================================

// Module: rpi_serial_port
// PURPOSE
//  Raspberry Pi side serial register port for TIPI, in the 50MHz clk domain.
//  Synchronises the asynchronous RPi serial lines (sclk, sle, regsel, data).
//  Deserialises RPi writes into the RD/RC registers that feed the TI read path.
//  Serialises TD/TC (TI-written latches) back to the RPi on rpi_sdata_in.
//  Replaces direct RPi-clocked shift registers, removing the rpi_sclk clock domain.
// PARAMETERS
//  SYNC_STAGES  2  flops per synchroniser on rpi_sclk/rpi_sle/rpi_regsel/rpi_sdata_out (>=2)
//  WIDTH        8  register width in bits; bit 0 = MSB (TI numbering)
// PORTS
//  clk            in   1      50MHz system clock; all state on rising edge
//  rst_n          in   1      synchronous reset, active low
//  rpi_sclk       in   1      RPi shift clock (async)
//  rpi_regsel     in   2      RPi register select: 00=RD 01=RC 10=TD 11=TC (async)
//  rpi_sdata_out  in   1      RPi->FPGA serial data, MSB first (async)
//  rpi_sle        in   1      RPi latch enable (async)
//  td_in          in   WIDTH  TD latch contents from TI side
//  tc_in          in   WIDTH  TC latch contents from TI side
//  rpi_sdata_in   out  1      FPGA->RPi serial data
//  rd_out         out  WIDTH  RD register to TI data bus mux
//  rc_out         out  WIDTH  RC register to TI data bus mux
//  rd_strobe      out  1      1-cycle pulse when rd_out updates
//  rc_strobe      out  1      1-cycle pulse when rc_out updates
//  frame_err      out  1      sticky: RD/RC commit with bit count != WIDTH
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): rd_out=rc_out=0, out_shift=0, rpi_sdata_in=0,
//   strobes=0, frame_err=0, bit_cnt=0, synchronisers and edge history=0.
//  Sync: each async input through SYNC_STAGES flops; edge detect on the last
//   stage vs one extra history flop. regsel/sdata_out sampled from sync outputs.
//  RPi timing contract: sclk/sle high and low each >= SYNC_STAGES+2 clk periods;
//   regsel/data stable SYNC_STAGES+2 clk before and after the relevant edge.
//  sclk rise (sync): in_shift <= {in_shift[1:WIDTH-1], sdata}; bit_cnt += 1,
//   saturating at 15 (4-bit counter).
//  sclk fall (sync): out_shift <= {out_shift[1:WIDTH-1], 1'b0}.
//  rpi_sdata_in = out_shift[0] (registered); RPi samples on its sclk rise.
//  sle rise (sync), by regsel:
//   00: rd_out <= in_shift; rd_strobe=1 next cycle only.
//   01: rc_out <= in_shift; rc_strobe=1 next cycle only.
//   10: out_shift <= td_in;  11: out_shift <= tc_in (sampled that cycle).
//   00/01 with bit_cnt != WIDTH: commit still happens, frame_err <= 1.
//   Every sle rise clears bit_cnt to 0; in_shift is NOT cleared.
//  Latency: rd_out/rc_out change exactly SYNC_STAGES+2 clk after first clk edge
//   sampling sle=1; rpi_sdata_in shows bit 0 of TD/TC at the same point.
//  Simultaneous sclk rise + sle rise (same cycle): shift applied first,
//   commit captures post-shift value; bit_cnt ends at 0.
//  Simultaneous sclk fall + sle rise (regsel 1x): parallel load wins.
//  sle fall and sle held high: no action. Extra sclk beyond WIDTH: oldest bits drop.
//  frame_err cleared only by reset. Reset mid-frame discards partial shift.
// TESTING
//  RD write: regsel=00, shift 8 bits 1010_0101, pulse sle -> rd_out=8'hA5,
//   rd_strobe one cycle at SYNC_STAGES+2 after sle, rc_out unchanged, frame_err=0.
//  TC read: tc_in=8'h3C, regsel=11, sle pulse, 8 sclk -> RPi samples 0,0,1,1,1,1,0,0
//   then 0s on further clocks.
//  Short frame: regsel=01, 5 bits then sle -> rc_out=last 8 in_shift bits,
//   frame_err=1 and stays 1 after later correct frames.
//  Same-cycle sclk rise + sle rise on 8th bit (regsel=00, 8'hFF) -> rd_out=8'hFF, no frame_err.
//  Reset mid-frame after 4 bits of 8'hF0 -> all outputs 0; next full frame
//   8'h81 commits 8'h81 with frame_err=0.
//  Timing contract: sclk half-period SYNC_STAGES+2 clk, random regsel sequence of
//   200 frames vs scoreboard -> zero mismatches.

Source files
------------

// File: rtl/rpi_serial_port.sv
// rpi_serial_port: RPi-side TIPI serial register port, running entirely in the clk domain.
// Async RPi lines are synchronised; RD/RC are deserialised from the RPi, TD/TC serialised back.
module rpi_serial_port #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rpi_sclk,
    input  logic [1:0]       rpi_regsel,
    input  logic             rpi_sdata_out,
    input  logic             rpi_sle,
    input  logic [0:WIDTH-1] td_in,
    input  logic [0:WIDTH-1] tc_in,
    output logic             rpi_sdata_in,
    output logic [0:WIDTH-1] rd_out,
    output logic [0:WIDTH-1] rc_out,
    output logic             rd_strobe,
    output logic             rc_strobe,
    output logic             frame_err
);

    logic [SYNC_STAGES-1:0]      sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]      sle_sync_q, sle_sync_d;
    logic [SYNC_STAGES-1:0]      sdata_sync_q, sdata_sync_d;
    logic [SYNC_STAGES-1:0][1:0] regsel_sync_q, regsel_sync_d;
    logic                        sclk_hist_q, sclk_hist_d;
    logic                        sle_hist_q, sle_hist_d;
    logic [1:0]                  sclk_rise_pipe_q, sclk_rise_pipe_d;
    logic [1:0]                  sclk_fall_pipe_q, sclk_fall_pipe_d;
    logic [1:0]                  sle_rise_pipe_q, sle_rise_pipe_d;
    logic [0:WIDTH-1]            in_shift_q, in_shift_d;
    logic [0:WIDTH-1]            out_shift_q, out_shift_d;
    logic [3:0]                  bit_cnt_q, bit_cnt_d;
    logic [0:WIDTH-1]            rd_out_q, rd_out_d;
    logic [0:WIDTH-1]            rc_out_q, rc_out_d;
    logic                        rd_strobe_q, rd_strobe_d;
    logic                        rc_strobe_q, rc_strobe_d;
    logic                        frame_err_q, frame_err_d;
    logic                        rpi_sdata_in_q, rpi_sdata_in_d;
    logic                        sdata;
    logic [1:0]                  regsel;
    logic                        frame_bad;

    always_comb begin
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], rpi_sclk};
        sle_sync_d    = {sle_sync_q[SYNC_STAGES-2:0], rpi_sle};
        sdata_sync_d  = {sdata_sync_q[SYNC_STAGES-2:0], rpi_sdata_out};
        regsel_sync_d = {regsel_sync_q[SYNC_STAGES-2:0], rpi_regsel};
        sclk_hist_d   = sclk_sync_q[SYNC_STAGES-1];
        sle_hist_d    = sle_sync_q[SYNC_STAGES-1];
        sdata         = sdata_sync_q[SYNC_STAGES-1];
        regsel        = regsel_sync_q[SYNC_STAGES-1];

        // Edge events ride two flops so every action lands SYNC_STAGES+2 clk after first sampling.
        sclk_rise_pipe_d = {sclk_rise_pipe_q[0], sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q};
        sclk_fall_pipe_d = {sclk_fall_pipe_q[0], ~sclk_sync_q[SYNC_STAGES-1] & sclk_hist_q};
        sle_rise_pipe_d  = {sle_rise_pipe_q[0], sle_sync_q[SYNC_STAGES-1] & ~sle_hist_q};

        in_shift_d  = in_shift_q;
        out_shift_d = out_shift_q;
        bit_cnt_d   = bit_cnt_q;
        rd_out_d    = rd_out_q;
        rc_out_d    = rc_out_q;
        rd_strobe_d = 1'b0;
        rc_strobe_d = 1'b0;
        frame_err_d = frame_err_q;
        frame_bad   = 1'b0;

        if (sclk_rise_pipe_q[1]) begin
            in_shift_d = {in_shift_q[1:WIDTH-1], sdata};
            if (bit_cnt_q != 4'hF) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
        if (sclk_fall_pipe_q[1]) begin
            out_shift_d = {out_shift_q[1:WIDTH-1], 1'b0};
        end

        // Commit sees the post-shift register and count, and a parallel load overrides a same-cycle shift.
        if (sle_rise_pipe_q[1]) begin
            frame_bad = (32'(bit_cnt_d) != WIDTH);
            bit_cnt_d = '0;
            case (regsel)
                2'b00: begin
                    rd_out_d    = in_shift_d;
                    rd_strobe_d = 1'b1;
                    if (frame_bad) frame_err_d = 1'b1;
                end
                2'b01: begin
                    rc_out_d    = in_shift_d;
                    rc_strobe_d = 1'b1;
                    if (frame_bad) frame_err_d = 1'b1;
                end
                2'b10:   out_shift_d = td_in;
                default: out_shift_d = tc_in;
            endcase
        end

        rpi_sdata_in_d = out_shift_d[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q      <= '0;
            sle_sync_q       <= '0;
            sdata_sync_q     <= '0;
            regsel_sync_q    <= '0;
            sclk_hist_q      <= 1'b0;
            sle_hist_q       <= 1'b0;
            sclk_rise_pipe_q <= '0;
            sclk_fall_pipe_q <= '0;
            sle_rise_pipe_q  <= '0;
            in_shift_q       <= '0;
            out_shift_q      <= '0;
            bit_cnt_q        <= '0;
            rd_out_q         <= '0;
            rc_out_q         <= '0;
            rd_strobe_q      <= 1'b0;
            rc_strobe_q      <= 1'b0;
            frame_err_q      <= 1'b0;
            rpi_sdata_in_q   <= 1'b0;
        end else begin
            sclk_sync_q      <= sclk_sync_d;
            sle_sync_q       <= sle_sync_d;
            sdata_sync_q     <= sdata_sync_d;
            regsel_sync_q    <= regsel_sync_d;
            sclk_hist_q      <= sclk_hist_d;
            sle_hist_q       <= sle_hist_d;
            sclk_rise_pipe_q <= sclk_rise_pipe_d;
            sclk_fall_pipe_q <= sclk_fall_pipe_d;
            sle_rise_pipe_q  <= sle_rise_pipe_d;
            in_shift_q       <= in_shift_d;
            out_shift_q      <= out_shift_d;
            bit_cnt_q        <= bit_cnt_d;
            rd_out_q         <= rd_out_d;
            rc_out_q         <= rc_out_d;
            rd_strobe_q      <= rd_strobe_d;
            rc_strobe_q      <= rc_strobe_d;
            frame_err_q      <= frame_err_d;
            rpi_sdata_in_q   <= rpi_sdata_in_d;
        end
    end

    always_comb begin
        rpi_sdata_in = rpi_sdata_in_q;
        rd_out       = rd_out_q;
        rc_out       = rc_out_q;
        rd_strobe    = rd_strobe_q;
        rc_strobe    = rc_strobe_q;
        frame_err    = frame_err_q;
    end

endmodule

// File: tb/tb_rpi_serial_port.sv
// tb_rpi_serial_port: directed and randomised RPi frames against a bit-stream reference model.
// The model tracks the whole shifted-in bit history and a plain bit count since the last latch.
module tb_rpi_serial_port;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned WIDTH       = 8;
    localparam int unsigned H           = SYNC_STAGES + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rpi_sclk;
    logic [1:0] rpi_regsel;
    logic       rpi_sdata_out;
    logic       rpi_sle;
    logic [7:0] td_in;
    logic [7:0] tc_in;
    logic       rpi_sdata_in;
    logic [7:0] rd_out;
    logic [7:0] rc_out;
    logic       rd_strobe;
    logic       rc_strobe;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_hist;
    logic [7:0] m_rd;
    logic [7:0] m_rc;
    logic [7:0] m_out;
    int         m_cnt;
    logic       m_err;
    int         m_rd_n = 0;
    int         m_rc_n = 0;
    int         rd_pulses = 0;
    int         rc_pulses = 0;

    rpi_serial_port #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rpi_sclk      (rpi_sclk),
        .rpi_regsel    (rpi_regsel),
        .rpi_sdata_out (rpi_sdata_out),
        .rpi_sle       (rpi_sle),
        .td_in         (td_in),
        .tc_in         (tc_in),
        .rpi_sdata_in  (rpi_sdata_in),
        .rd_out        (rd_out),
        .rc_out        (rc_out),
        .rd_strobe     (rd_strobe),
        .rc_strobe     (rc_strobe),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_strobe) rd_pulses <= rd_pulses + 1;
        if (rc_strobe) rc_pulses <= rc_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_reset();
        m_hist = '0;
        m_rd   = '0;
        m_rc   = '0;
        m_out  = '0;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    task automatic m_latch(input logic [1:0] sel);
        case (sel)
            2'd0: begin m_rd = m_hist; m_rd_n++; if (m_cnt != 8) m_err = 1'b1; end
            2'd1: begin m_rc = m_hist; m_rc_n++; if (m_cnt != 8) m_err = 1'b1; end
            2'd2: m_out = td_in;
            default: m_out = tc_in;
        endcase
        m_cnt = 0;
    endtask

    // One RPi bit: data set, sclk rise, sample FPGA data late in the high phase, sclk fall.
    task automatic rpi_bit(input logic b, output logic sampled);
        rpi_sdata_out = b;
        wait_clk(H);
        rpi_sclk = 1'b1;
        m_hist = {m_hist[6:0], b};
        m_cnt++;
        wait_clk(H);
        sampled = rpi_sdata_in;
        chk("sdata_in", rpi_sdata_in, m_out[7]);
        rpi_sclk = 1'b0;
        m_out = {m_out[6:0], 1'b0};
    endtask

    task automatic rpi_latch(input logic [1:0] sel);
        rpi_regsel = sel;
        wait_clk(H);
        rpi_sle = 1'b1;
        m_latch(sel);
        wait_clk(H);
        rpi_sle = 1'b0;
        wait_clk(H);
    endtask

    task automatic check_regs();
        chk("rd_out", rd_out, m_rd);
        chk("rc_out", rc_out, m_rc);
        chk("frame_err", frame_err, m_err);
        chk("rd_pulses", rd_pulses, m_rd_n);
        chk("rc_pulses", rc_pulses, m_rc_n);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rpi_sclk = 1'b0;
        rpi_sle  = 1'b0;
        wait_clk(3);
        chk("rst_rd_out", rd_out, 8'h00);
        chk("rst_rc_out", rc_out, 8'h00);
        chk("rst_sdata_in", rpi_sdata_in, 1'b0);
        chk("rst_rd_strobe", rd_strobe, 1'b0);
        chk("rst_rc_strobe", rc_strobe, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        m_reset();
        wait_clk(1);
    endtask

    initial begin
        logic       s;
        logic [7:0] v;
        logic [1:0] sel;
        int         n;

        rst_n         = 1'b0;
        rpi_sclk      = 1'b0;
        rpi_regsel    = 2'b00;
        rpi_sdata_out = 1'b0;
        rpi_sle       = 1'b0;
        td_in         = 8'h00;
        tc_in         = 8'h00;
        m_reset();
        do_reset();

        // RD write 0xA5 with commit/strobe latency check
        v = 8'hA5;
        rpi_regsel = 2'b00;
        for (int i = 7; i >= 0; i--) rpi_bit(v[i], s);
        wait_clk(H);
        rpi_sle = 1'b1;
        m_latch(2'd0);
        for (int unsigned i = 1; i <= 2 * H; i++) begin
            @(negedge clk);
            chk("rd_strobe_lat", rd_strobe, (i == SYNC_STAGES + 3));
            chk("rd_out_lat", rd_out, (i >= SYNC_STAGES + 3) ? 8'hA5 : 8'h00);
        end
        rpi_sle = 1'b0;
        wait_clk(H);
        check_regs();

        // TC read 0x3C: RPi sees 0,0,1,1,1,1,0,0 then zeros
        tc_in = 8'h3C;
        td_in = 8'($urandom);
        rpi_latch(2'd3);
        v = tc_in;
        for (int i = 0; i < 10; i++) begin
            rpi_bit(1'($urandom_range(0, 1)), s);
            chk("tc_read", s, (i < 8) ? v[7 - i] : 1'b0);
        end

        // Short RC frame sets sticky frame_err
        rpi_latch(2'd2);
        for (int i = 0; i < 5; i++) rpi_bit(1'($urandom_range(0, 1)), s);
        rpi_latch(2'd1);
        check_regs();
        chk("short_err", frame_err, 1'b1);
        v = 8'h5A;
        for (int i = 7; i >= 0; i--) rpi_bit(v[i], s);
        rpi_latch(2'd0);
        check_regs();
        chk("err_sticky", frame_err, 1'b1);

        // Reset mid-frame, then a clean 0x81 frame
        v = 8'hF0;
        rpi_regsel = 2'b00;
        for (int i = 7; i >= 4; i--) rpi_bit(v[i], s);
        do_reset();
        v = 8'h81;
        for (int i = 7; i >= 0; i--) rpi_bit(v[i], s);
        rpi_latch(2'd0);
        check_regs();
        chk("post_rst_rd", rd_out, 8'h81);

        // sclk rise and sle rise together on the 8th bit of 0xFF
        rpi_regsel = 2'b00;
        for (int i = 0; i < 7; i++) rpi_bit(1'b1, s);
        rpi_sdata_out = 1'b1;
        wait_clk(H);
        rpi_sclk = 1'b1;
        rpi_sle  = 1'b1;
        m_hist = {m_hist[6:0], 1'b1};
        m_cnt++;
        m_latch(2'd0);
        wait_clk(H);
        rpi_sclk = 1'b0;
        rpi_sle  = 1'b0;
        m_out = {m_out[6:0], 1'b0};
        wait_clk(2 * H);
        check_regs();
        chk("same_cycle_rd", rd_out, 8'hFF);
        v = 8'($urandom);
        for (int i = 7; i >= 0; i--) rpi_bit(v[i], s);
        rpi_latch(2'd1);
        check_regs();

        // sclk fall and TD load together: the load wins
        td_in = 8'($urandom);
        rpi_regsel = 2'b10;
        rpi_sdata_out = 1'b0;
        wait_clk(H);
        rpi_sclk = 1'b1;
        m_hist = {m_hist[6:0], 1'b0};
        m_cnt++;
        wait_clk(H);
        rpi_sclk = 1'b0;
        rpi_sle  = 1'b1;
        m_out = {m_out[6:0], 1'b0};
        m_latch(2'd2);
        wait_clk(H);
        rpi_sle = 1'b0;
        wait_clk(H);
        for (int i = 0; i < 8; i++) rpi_bit(1'($urandom_range(0, 1)), s);

        // Random frames at the minimum contract timing
        for (int f = 0; f < 200; f++) begin
            if (f % 50 == 0) do_reset();
            sel   = 2'($urandom_range(0, 3));
            td_in = 8'($urandom);
            tc_in = 8'($urandom);
            if (sel < 2'd2) begin
                n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : 8;
                for (int i = 0; i < n; i++) rpi_bit(1'($urandom_range(0, 1)), s);
                rpi_latch(sel);
            end else begin
                rpi_latch(sel);
                n = int'($urandom_range(6, 10));
                for (int i = 0; i < n; i++) rpi_bit(1'($urandom_range(0, 1)), s);
            end
            check_regs();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
